// File: rtl/adc_serial_capture_if.sv
// ---------------------------------------------------------------------------
// adc_serial_capture_if
//
// Purpose : groups the converter-side serial link and the sample-side outputs
//           of adc_serial_capture into one bundle.
//
// Signals :
//   en        run request (high = back-to-back conversions)
//   adc_do    serial data from the ADC0831-style converter
//   adc_cs_n  converter chip select, active low
//   adc_sclk  converter serial clock, idle low
//   adc       4-bit quantized sample, held between updates
//   valid     one-cycle pulse when adc takes a new value
//   busy      high while adc_cs_n is low
//   err       sticky null-bit error flag
//
// Modports:
//   master    the capture block (drives the converter link and the results)
//   slave     the environment (drives en and adc_do, observes the rest)
// ---------------------------------------------------------------------------
interface adc_serial_capture_if;

  logic       en;
  logic       adc_do;
  logic       adc_cs_n;
  logic       adc_sclk;
  logic [3:0] adc;
  logic       valid;
  logic       busy;
  logic       err;

  modport master (
    input  en,
    input  adc_do,
    output adc_cs_n,
    output adc_sclk,
    output adc,
    output valid,
    output busy,
    output err
  );

  modport slave (
    output en,
    output adc_do,
    input  adc_cs_n,
    input  adc_sclk,
    input  adc,
    input  valid,
    input  busy,
    input  err
  );

endinterface

// File: rtl/adc_serial_capture.sv
// ---------------------------------------------------------------------------
// adc_serial_capture
//
// Purpose : drives an ADC0831-style 8-bit serial converter, captures each
//           conversion MSB first and reduces it to a rounded, saturated
//           4-bit value for a downstream 7-segment decoder.
//
// A conversion is: SETUP (one SCLK period, data ignored), NULLBIT (one SCLK
// period, the bit must read 0), SHIFT (eight SCLK periods, MSB first), then a
// single DONE cycle that publishes the result, then SAMPLE_GAP idle cycles.
// Chip select is low for exactly 10 SCLK periods = 20*CLK_DIV clocks.
//
// Parameters:
//   CLK_DIV     clk cycles per SCLK half-period (2..255)
//   SAMPLE_GAP  idle clk cycles between conversions (1..65535)
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   bus         adc_serial_capture_if.master (en, adc_do in;
//               adc_cs_n, adc_sclk, adc, valid, busy, err out)
// ---------------------------------------------------------------------------
module adc_serial_capture #(
  parameter int unsigned CLK_DIV    = 25,
  parameter int unsigned SAMPLE_GAP = 1000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  adc_serial_capture_if.master        bus
);

  localparam logic [7:0]  DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [15:0] GAP_LAST = 16'(SAMPLE_GAP - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_NULLBIT = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_DONE    = 3'd4,
    ST_GAP     = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;

  logic [7:0]  div_r;
  logic [15:0] gap_r;
  logic [2:0]  bit_r;
  logic [7:0]  shift_r;
  logic        sclk_r;
  logic        cs_n_r;
  logic        busy_r;
  logic        valid_r;
  logic        err_r;
  logic [3:0]  adc_r;

  logic        active_s;
  logic        active_next_s;
  logic        tick_s;
  logic        rise_s;
  logic        fall_s;
  logic        enter_setup_s;

  // Round to nearest and saturate: min((s + 8) >> 4, 15) in 9 bits.
  // Bit 8 of the sum is only set for s >= 0xF8, where the true result is 16.
  function automatic logic [3:0] quantize(input logic [7:0] s);
    logic [8:0] sum;
    sum = {1'b0, s} + 9'd8;
    if (sum[8]) begin
      quantize = 4'hF;
    end else begin
      quantize = sum[7:4];
    end
  endfunction

  // Divider/SCLK activity decode and tick qualification.
  always_comb begin
    active_s      = 1'b0;
    active_next_s = 1'b0;
    tick_s        = 1'b0;
    rise_s        = 1'b0;
    fall_s        = 1'b0;
    enter_setup_s = 1'b0;

    active_s      = (state_r == ST_SETUP) || (state_r == ST_NULLBIT) ||
                    (state_r == ST_SHIFT);
    active_next_s = (state_s == ST_SETUP) || (state_s == ST_NULLBIT) ||
                    (state_s == ST_SHIFT);
    tick_s        = active_s && (div_r == DIV_LAST);
    // sclk_r is the level before the toggle: low means this tick is the
    // 0->1 edge where adc_do is sampled.
    rise_s        = tick_s && !sclk_r;
    fall_s        = tick_s && sclk_r;
    enter_setup_s = (state_s == ST_SETUP) && (state_r != ST_SETUP);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic; each phase ends on a falling SCLK tick so SCLK
  // is always back low when the phase changes.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.en) begin
          state_s = ST_SETUP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (fall_s) begin
          state_s = ST_NULLBIT;
        end else begin
          state_s = ST_SETUP;
        end
      end
      ST_NULLBIT: begin
        if (fall_s) begin
          state_s = ST_SHIFT;
        end else begin
          state_s = ST_NULLBIT;
        end
      end
      ST_SHIFT: begin
        if (fall_s && (bit_r == 3'd7)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_SHIFT;
        end
      end
      ST_DONE: begin
        state_s = ST_GAP;
      end
      ST_GAP: begin
        if (gap_r == GAP_LAST) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_GAP;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // SCLK half-period divider; runs only while the converter is selected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r <= 8'd0;
    end else if (enter_setup_s || !active_s || tick_s) begin
      div_r <= 8'd0;
    end else begin
      div_r <= div_r + 8'd1;
    end
  end

  // SCLK generator: toggles on every divider tick, forced low otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_r <= 1'b0;
    end else if (tick_s) begin
      sclk_r <= ~sclk_r;
    end else if (!active_s) begin
      sclk_r <= 1'b0;
    end else begin
      sclk_r <= sclk_r;
    end
  end

  // Data-bit counter: advances on each falling SCLK in SHIFT, wraps to 0
  // after the eighth bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_r <= 3'd0;
    end else if (state_r != ST_SHIFT) begin
      bit_r <= 3'd0;
    end else if (fall_s) begin
      bit_r <= bit_r + 3'd1;
    end else begin
      bit_r <= bit_r;
    end
  end

  // MSB-first shift register loaded on rising SCLK in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_r <= 8'd0;
    end else if ((state_r == ST_SHIFT) && rise_s) begin
      shift_r <= {shift_r[6:0], bus.adc_do};
    end else begin
      shift_r <= shift_r;
    end
  end

  // Sticky error: the null bit sampled on its rising SCLK must be 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if ((state_r == ST_NULLBIT) && rise_s && bus.adc_do) begin
      err_r <= 1'b1;
    end else begin
      err_r <= err_r;
    end
  end

  // Inter-conversion gap counter; counts 0..SAMPLE_GAP-1 while in GAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_r <= 16'd0;
    end else if ((state_r == ST_GAP) && (state_s == ST_GAP)) begin
      gap_r <= gap_r + 16'd1;
    end else begin
      gap_r <= 16'd0;
    end
  end

  // Registered outputs, decoded from the next state so they line up with
  // the state register cycle for cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_n_r  <= 1'b1;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      adc_r   <= 4'd0;
    end else begin
      cs_n_r  <= ~active_next_s;
      busy_r  <= active_next_s;
      valid_r <= (state_s == ST_DONE);
      if (state_s == ST_DONE) begin
        adc_r <= quantize(shift_r);
      end else begin
        adc_r <= adc_r;
      end
    end
  end

  assign bus.adc_cs_n = cs_n_r;
  assign bus.adc_sclk = sclk_r;
  assign bus.adc      = adc_r;
  assign bus.valid    = valid_r;
  assign bus.busy     = busy_r;
  assign bus.err      = err_r;

endmodule

// File: tb/tb_adc_serial_capture.sv
// ---------------------------------------------------------------------------
// tb_adc_serial_capture
//
// Self-checking bench for adc_serial_capture. A converter model serves frames
// (null bit + data byte) from a queue; for every frame it serves, the
// expected 4-bit result is computed arithmetically and queued. A cycle
// monitor checks every VALID pulse against that queue and measures chip
// select timing, SCLK period and gap length.
// ---------------------------------------------------------------------------
module tb_adc_serial_capture;

  localparam int CLK_DIV    = 2;
  localparam int SAMPLE_GAP = 7;
  localparam int CS_LOW     = 20 * CLK_DIV;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  adc_serial_capture_if bus ();

  adc_serial_capture #(
    .CLK_DIV    (CLK_DIV),
    .SAMPLE_GAP (SAMPLE_GAP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_err   = 0;
  int n_valid = 0;
  int n_falls = 0;
  int exp_err = 0;
  int frame_q[$];
  int exp_q[$];

  task automatic chk(input string tag, input int obs, input int exp_v);
    n_cmp++;
    if (obs != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int mk(input int nullbit, input int data);
    return (nullbit << 8) | (data & 255);
  endfunction

  // Reference quantizer: nearest of 16 levels, clipped at 15.
  function automatic int ref_adc(input int data);
    int r;
    r = (data + 8) / 16;
    if (r > 15) r = 15;
    return r;
  endfunction

  // Bit the converter presents before SCLK rise number idx (0-based):
  // 0 = settle period (junk 1), 1 = null bit, 2..9 = data MSB first.
  function automatic logic frame_bit(input int f, input int idx);
    if (idx == 0) return 1'b1;
    if (idx == 1) return f[8];
    if (idx >= 2 && idx <= 9) return f[9 - idx];
    return 1'b0;
  endfunction

  // Converter model.
  initial begin : converter
    int cur;
    int idx;
    cur = 0;
    idx = 0;
    bus.adc_do = 1'b0;
    forever begin
      @(negedge bus.adc_cs_n or posedge bus.adc_sclk);
      if (bus.adc_sclk) begin
        idx++;
      end else begin
        if (frame_q.size() > 0) cur = frame_q.pop_front();
        else cur = mk(0, int'($urandom_range(0, 255)));
        exp_q.push_back(ref_adc(cur & 255));
        if (cur[8]) exp_err = 1;
        idx = 0;
      end
      bus.adc_do = frame_bit(cur, idx);
    end
  end

  // Cycle monitor, sampling on the falling clock edge.
  initial begin : monitor
    int cyc, lowcnt, highcnt, last_rise, fall_cyc, rises, prev_adc, e;
    bit prev_valid, prev_sclk, gap_armed, en_held;
    cyc = 0; lowcnt = 0; highcnt = 0; last_rise = 0; fall_cyc = 0; rises = 0;
    prev_adc = 0; e = 0;
    prev_valid = 0; prev_sclk = 0; gap_armed = 0; en_held = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        lowcnt = 0; highcnt = 0; rises = 0; gap_armed = 0;
        prev_valid = 0; prev_sclk = 0; prev_adc = bus.adc;
      end else begin
        chk("busy_vs_cs", bus.busy, !bus.adc_cs_n);
        if (bus.adc_cs_n) chk("sclk_idle_low", bus.adc_sclk, 0);
        if (bus.valid) begin
          n_valid++;
          chk("valid_single", prev_valid, 0);
          chk("valid_cs_high", bus.adc_cs_n, 1);
          if (exp_q.size() == 0) begin
            chk("valid_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("adc_value", bus.adc, e);
          end
          chk("err_flag", bus.err, exp_err);
        end else if (bus.adc != prev_adc) begin
          chk("adc_hold", bus.adc, prev_adc);
        end
        if (!bus.adc_cs_n) begin
          if (lowcnt == 0) begin
            n_falls++;
            rises = 0;
            fall_cyc = cyc;
            if (gap_armed && en_held) chk("cs_high_gap", highcnt, SAMPLE_GAP + 2);
            gap_armed = 0;
          end
          lowcnt++;
          if (bus.adc_sclk && !prev_sclk) begin
            if (rises == 0) chk("first_sclk_rise", cyc - fall_cyc, CLK_DIV);
            else chk("sclk_period", cyc - last_rise, 2 * CLK_DIV);
            rises++;
            last_rise = cyc;
          end
        end else begin
          if (lowcnt > 0) begin
            chk("cs_low_len", lowcnt, CS_LOW);
            chk("sclk_rises", rises, 10);
            gap_armed = 1;
            en_held = 1;
            highcnt = 0;
          end
          lowcnt = 0;
          highcnt++;
          if (!bus.en) en_held = 0;
        end
        prev_valid = bus.valid;
        prev_sclk = bus.adc_sclk;
        prev_adc = bus.adc;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit, got %0d compared, expected completion", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_valid(input int target, input int budget);
    int k;
    k = 0;
    while (n_valid < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (n_valid < target) chk("valid_timeout", n_valid, target);
  endtask

  // Waits for a fresh high-to-low chip select transition.
  task automatic wait_cs_fall(input int budget);
    int k;
    k = 0;
    while (!bus.adc_cs_n && k < budget) begin
      @(negedge clk);
      k++;
    end
    while (bus.adc_cs_n && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("cs_fall_timeout", k, 0);
  endtask

  task automatic wait_sclk_rises(input int n, input int budget);
    int k, seen;
    logic prev;
    k = 0;
    seen = 0;
    prev = bus.adc_sclk;
    while (seen < n && k < budget) begin
      @(negedge clk);
      k++;
      if (bus.adc_sclk && !prev) seen++;
      prev = bus.adc_sclk;
    end
    if (seen < n) chk("sclk_rise_timeout", seen, n);
  endtask

  task automatic reset_checks(input string pfx);
    chk({pfx, "_cs_n"},  bus.adc_cs_n, 1);
    chk({pfx, "_sclk"},  bus.adc_sclk, 0);
    chk({pfx, "_adc"},   bus.adc,      0);
    chk({pfx, "_valid"}, bus.valid,    0);
    chk({pfx, "_busy"},  bus.busy,     0);
    chk({pfx, "_err"},   bus.err,      0);
  endtask

  initial begin : stim
    int base, fb, d;
    int bnd[7];
    bnd = '{8'h08, 8'h07, 8'hFC, 8'hF7, 8'hF8, 8'hFF, 8'h00};
    bus.en = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_checks("por");
    frame_q.delete();
    exp_q.delete();
    exp_err = 0;
    @(negedge clk) rst_n = 1'b1;

    // Enable low: nothing starts.
    repeat (10) @(negedge clk);
    chk("idle_cs_n_en_low", bus.adc_cs_n, 1);
    chk("idle_no_valid", n_valid, 0);

    // Single conversion of 0x5A.
    frame_q.push_back(mk(0, 8'h5A));
    bus.en = 1'b1;
    wait_valid(1, 400);
    chk("first_adc", bus.adc, 6);
    chk("first_err", bus.err, 0);

    // Rounding and saturation boundaries, back to back.
    base = n_valid;
    foreach (bnd[i]) frame_q.push_back(mk(0, bnd[i]));
    wait_valid(base + 7, 7 * 200);
    chk("bnd_last_adc", bus.adc, 0);

    // Random data.
    base = n_valid;
    for (int i = 0; i < 8; i++) begin
      d = int'($urandom_range(0, 255));
      frame_q.push_back(mk(0, d));
    end
    wait_valid(base + 8, 8 * 200);

    // Enable glitch while in GAP is ignored: conversions continue.
    base = n_valid;
    wait_valid(base + 1, 200);
    bus.en = 1'b0;
    repeat (3) @(negedge clk);
    bus.en = 1'b1;
    wait_valid(base + 2, 400);
    chk("gap_glitch_continues", n_valid, base + 2);

    // Enable dropped during the third data bit: finish, then park.
    wait_cs_fall(400);
    wait_sclk_rises(5, 200);
    bus.en = 1'b0;
    base = n_valid;
    fb = n_falls;
    wait_valid(base + 1, 200);
    repeat (SAMPLE_GAP + 60) @(negedge clk);
    chk("en_drop_one_valid", n_valid, base + 1);
    chk("en_drop_no_restart", n_falls, fb);
    chk("parked_cs_n", bus.adc_cs_n, 1);
    chk("parked_busy", bus.busy, 0);
    chk("exp_drained", exp_q.size(), 0);

    // Null bit read as 1: sticky error, result still published.
    base = n_valid;
    frame_q.push_back(mk(1, 8'h40));
    bus.en = 1'b1;
    wait_valid(base + 1, 400);
    chk("null_err_set", bus.err, 1);
    chk("null_adc", bus.adc, 4);
    frame_q.push_back(mk(0, int'($urandom_range(0, 255))));
    wait_valid(base + 2, 400);
    chk("err_sticky", bus.err, 1);

    // Reset in the middle of SHIFT aborts the conversion.
    frame_q.push_back(mk(0, 8'h99));
    wait_cs_fall(400);
    wait_sclk_rises(4, 200);
    base = n_valid;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 reset_checks("mid");
    repeat (3) @(negedge clk);
    chk("abort_no_valid", n_valid, base);
    frame_q.delete();
    exp_q.delete();
    exp_err = 0;
    frame_q.push_back(mk(0, 8'hB3));
    rst_n = 1'b1;
    wait_valid(base + 1, 400);
    chk("post_reset_adc", bus.adc, 11);
    chk("post_reset_err", bus.err, 0);

    bus.en = 1'b0;
    repeat (SAMPLE_GAP + 60) @(negedge clk);
    chk("final_drained", exp_q.size(), 0);
    chk("final_cs_n", bus.adc_cs_n, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
